nemesis_sound_mixer: RTL and testbench

- Final audio stage of the Nemesis sound board. It consumes the two PROM wavetable voices and the two AY-3-8910 outputs (AY7, AY8), plus the per-source enables and 8-bit balance gains from the sound debug/config block.
- It produces one signed 16-bit mono sample per sample strobe.
- A single multiplier is time-multiplexed over the four sources, with accumulate, scale and saturate steps.
- Output feeds the platform audio FIFO/DAC interface.

---
 rtl/nemesis_sound_mixer.sv | 174 +++++++++++++++++
 tb/tb_nemesis_sound_mixer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/nemesis_sound_mixer.sv
// Final audio mixer: four sources (PROM1, PROM2, AY7, AY8) into one signed 16-bit mono sample.
// Latency: strobe on edge N -> o_sample/o_sample_valid after edge N+5; one shared multiplier, one source per cycle.
// Backpressure: none; a strobe during a mix is dropped and flagged on o_overrun, so strobes must be >= 6 cycles apart.
//
// Ports: i_clk/i_reset (async, active-high), i_cen_sample strobe, source samples i_prom1/2 (8b, mid 0x80),
//        i_ay7/8 (10b, mid 0x200), per-source enables, gains i_bal_prom/ay7/ay8 (8b, 128 = x1.0);
//        o_sample/o_sample_valid result, o_busy, o_overrun pulse, o_clip sticky saturation flag.
// Optional: define NEMESIS_MIXER_PEAK_EN to add i_peak_clr / o_peak (peak |o_sample| tracker).
module nemesis_sound_mixer #(
    parameter int OUT_SHIFT  = 3,
    parameter int UNITY_GAIN = 128
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_cen_sample,
    input  logic [7:0]  i_prom1,
    input  logic [7:0]  i_prom2,
    input  logic [9:0]  i_ay7,
    input  logic [9:0]  i_ay8,
    input  logic        i_prom1_on,
    input  logic        i_prom2_on,
    input  logic        i_ay7_on,
    input  logic        i_ay8_on,
    input  logic [7:0]  i_bal_prom,
    input  logic [7:0]  i_bal_ay7,
    input  logic [7:0]  i_bal_ay8,
`ifdef NEMESIS_MIXER_PEAK_EN
    input  logic        i_peak_clr,
    output logic [14:0] o_peak,
`endif
    output logic [15:0] o_sample,
    output logic        o_sample_valid,
    output logic        o_busy,
    output logic        o_overrun,
    output logic        o_clip
);

    // The gain code is applied raw; UNITY_GAIN only documents what x1.0 means and must be a legal code.
    if (UNITY_GAIN < 1 || UNITY_GAIN > 255) begin : g_bad_unity
        $error("UNITY_GAIN must be an 8-bit gain code");
    end

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_MAC0 = 3'd1;
    localparam logic [2:0] S_MAC1 = 3'd2;
    localparam logic [2:0] S_MAC2 = 3'd3;
    localparam logic [2:0] S_MAC3 = 3'd4;
    localparam logic [2:0] S_OUT  = 3'd5;

    logic [2:0]         state;
    logic [7:0]         prom1_q, prom2_q;
    logic [9:0]         ay7_q, ay8_q;
    logic [3:0]         on_q;           // {ay8, ay7, prom2, prom1}
    logic [7:0]         bal_prom_q, bal_ay7_q, bal_ay8_q;
    logic signed [19:0] acc;

    // Source select for the shared multiplier. Offset-binary to two's complement is just an MSB flip;
    // PROM voices are pre-scaled by 4 so both source types share the 10-bit signed range.
    logic signed [9:0]  term;
    logic [7:0]         gain;
    logic               term_en;
    logic signed [17:0] term_x, gain_x, product;
    logic signed [19:0] acc_next;

    always_comb begin
        term    = '0;
        gain    = '0;
        term_en = 1'b0;
        case (state)
            S_MAC0: begin term = {~prom1_q[7], prom1_q[6:0], 2'b00}; gain = bal_prom_q; term_en = on_q[0]; end
            S_MAC1: begin term = {~prom2_q[7], prom2_q[6:0], 2'b00}; gain = bal_prom_q; term_en = on_q[1]; end
            S_MAC2: begin term = {~ay7_q[9], ay7_q[8:0]};            gain = bal_ay7_q;  term_en = on_q[2]; end
            S_MAC3: begin term = {~ay8_q[9], ay8_q[8:0]};            gain = bal_ay8_q;  term_en = on_q[3]; end
            default: ;
        endcase
        term_x   = {{8{term[9]}}, term};
        gain_x   = {10'd0, gain};
        // |term x gain| <= 512*255, so the 18-bit product never wraps.
        product  = term_en ? term_x * gain_x : '0;
        acc_next = acc + {{2{product[17]}}, product};
    end

    // Scale and saturate the finished accumulator.
    logic signed [19:0] scaled;
    logic               sat_hi, sat_lo;
    logic [15:0]        sample_next;

    always_comb begin
        scaled      = acc >>> OUT_SHIFT;
        sat_hi      = scaled > 20'sd32767;
        sat_lo      = scaled < -20'sd32768;
        sample_next = sat_hi ? 16'h7FFF : (sat_lo ? 16'h8000 : scaled[15:0]);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state          <= S_IDLE;
            prom1_q        <= '0;
            prom2_q        <= '0;
            ay7_q          <= '0;
            ay8_q          <= '0;
            on_q           <= '0;
            bal_prom_q     <= '0;
            bal_ay7_q      <= '0;
            bal_ay8_q      <= '0;
            acc            <= '0;
            o_sample       <= '0;
            o_sample_valid <= 1'b0;
            o_busy         <= 1'b0;
            o_overrun      <= 1'b0;
            o_clip         <= 1'b0;
        end else begin
            o_sample_valid <= 1'b0;
            // Registered view of "not idle", so busy spans edges N+1..N+5 of a mix.
            o_busy         <= (state != S_IDLE);
            o_overrun      <= i_cen_sample && (state != S_IDLE);
            case (state)
                S_IDLE: begin
                    if (i_cen_sample) begin
                        prom1_q    <= i_prom1;
                        prom2_q    <= i_prom2;
                        ay7_q      <= i_ay7;
                        ay8_q      <= i_ay8;
                        on_q       <= {i_ay8_on, i_ay7_on, i_prom2_on, i_prom1_on};
                        bal_prom_q <= i_bal_prom;
                        bal_ay7_q  <= i_bal_ay7;
                        bal_ay8_q  <= i_bal_ay8;
                        acc        <= '0;
                        state      <= S_MAC0;
                    end
                end
                S_MAC0, S_MAC1, S_MAC2: begin
                    acc   <= acc_next;
                    state <= state + 3'd1;
                end
                S_MAC3: begin
                    acc   <= acc_next;
                    state <= S_OUT;
                end
                S_OUT: begin
                    o_sample       <= sample_next;
                    o_sample_valid <= 1'b1;
                    if (sat_hi || sat_lo) o_clip <= 1'b1;
                    state          <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef NEMESIS_MIXER_PEAK_EN
    // Magnitude of the sample being published; -32768 clamps to 32767 to fit 15 bits.
    logic [15:0] sample_neg;
    logic [14:0] sample_mag;

    always_comb begin
        sample_neg = -sample_next;
        if (!sample_next[15])            sample_mag = sample_next[14:0];
        else if (sample_next == 16'h8000) sample_mag = 15'h7FFF;
        else                             sample_mag = sample_neg[14:0];
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_peak <= '0;
        end else if (i_peak_clr) begin
            o_peak <= '0;
        end else if (state == S_OUT && sample_mag > o_peak) begin
            o_peak <= sample_mag;
        end
    end
`endif

endmodule

// File: tb/tb_nemesis_sound_mixer.sv
// Self-checking bench for nemesis_sound_mixer: a cycle-level model of the mix schedule plus
// directed scenarios (unity, silence, saturation, enables, snapshot/overrun, reset mid-mix).
module tb_nemesis_sound_mixer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cen = 1'b0;
    logic [7:0]  prom1 = 8'h80, prom2 = 8'h80;
    logic [9:0]  ay7 = 10'h200, ay8 = 10'h200;
    logic        p1on = 1'b0, p2on = 1'b0, a7on = 1'b0, a8on = 1'b0;
    logic [7:0]  bal_prom = 8'd0, bal_ay7 = 8'd0, bal_ay8 = 8'd0;
    logic [15:0] o_sample;
    logic        o_sample_valid, o_busy, o_overrun, o_clip;

    int tests = 0;
    int fails = 0;
    int vcount = 0;

    always #5 clk = ~clk;

    nemesis_sound_mixer dut (
        .i_clk(clk), .i_reset(rst), .i_cen_sample(cen),
        .i_prom1(prom1), .i_prom2(prom2), .i_ay7(ay7), .i_ay8(ay8),
        .i_prom1_on(p1on), .i_prom2_on(p2on), .i_ay7_on(a7on), .i_ay8_on(a8on),
        .i_bal_prom(bal_prom), .i_bal_ay7(bal_ay7), .i_bal_ay8(bal_ay8),
        .o_sample(o_sample), .o_sample_valid(o_sample_valid), .o_busy(o_busy),
        .o_overrun(o_overrun), .o_clip(o_clip)
    );

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Mix from the arithmetic rules: centre each source, scale PROMs by 4, multiply by gain,
    // sum, divide by 8 rounding toward -inf, clamp to 16-bit signed.
    function automatic void mix(input int p1, input int p2, input int a7, input int a8, input bit [3:0] en,
                                input int bp, input int b7, input int b8, output int smp, output bit clip);
        int acc;
        int s;
        acc = 0;
        if (en[0]) acc += (p1 - 128) * 4 * bp;
        if (en[1]) acc += (p2 - 128) * 4 * bp;
        if (en[2]) acc += (a7 - 512) * b7;
        if (en[3]) acc += (a8 - 512) * b8;
        s = acc >>> 3;
        clip = (s > 32767) || (s < -32768);
        smp = (s > 32767) ? 32767 : ((s < -32768) ? -32768 : s);
    endfunction

    // Model state: m_since = edges elapsed since the accepting edge (-1 when no mix is running).
    int m_since = -1;
    int m_sample = 0, m_pend = 0;
    bit m_pend_clip = 0;
    bit m_valid = 0, m_busy = 0, m_ovr = 0, m_clip = 0;

    always @(negedge clk) begin
        int old;
        if (rst) begin
            m_since = -1; m_sample = 0; m_valid = 0; m_busy = 0; m_ovr = 0; m_clip = 0;
        end
        if (o_sample_valid) vcount++;
        chk("sample", $signed(o_sample), m_sample);
        chk("valid", int'(o_sample_valid), int'(m_valid));
        chk("busy", int'(o_busy), int'(m_busy));
        chk("overrun", int'(o_overrun), int'(m_ovr));
        chk("clip", int'(o_clip), int'(m_clip));
        // Predict the effect of the coming rising edge from the inputs now on the pins.
        if (!rst) begin
            old     = m_since;
            m_valid = 0;
            m_busy  = (old >= 0 && old <= 4);
            m_ovr   = cen && (old >= 0 && old <= 4);
            if (old >= 0 && old <= 4) begin
                m_since = old + 1;
                if (m_since == 5) begin
                    m_valid  = 1;
                    m_sample = m_pend;
                    if (m_pend_clip) m_clip = 1;
                end
            end else if (cen) begin
                m_since = 0;
                mix(prom1, prom2, ay7, ay8, {a8on, a7on, p2on, p1on}, bal_prom, bal_ay7, bal_ay8,
                    m_pend, m_pend_clip);
            end else begin
                m_since = -1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setup(input logic [7:0] p1, input logic [7:0] p2, input logic [9:0] a7, input logic [9:0] a8,
                         input logic [3:0] en, input logic [7:0] bp, input logic [7:0] b7, input logic [7:0] b8);
        prom1 = p1; prom2 = p2; ay7 = a7; ay8 = a8;
        {a8on, a7on, p2on, p1on} = en;
        bal_prom = bp; bal_ay7 = b7; bal_ay8 = b8;
    endtask

    // Raise the strobe so that the next edge (N) samples it; returns just after edge N.
    task automatic strobe();
        cen = 1'b1;
        tick();
        cen = 1'b0;
    endtask

    // Full mix: strobe, then stop just after edge N+5 where the result is visible.
    task automatic run_mix(input string name, input int exp_sample, input int exp_clip);
        int v0;
        v0 = vcount;
        strobe();
        repeat (5) tick();
        chk({name, "_sample"}, $signed(o_sample), exp_sample);
        chk({name, "_valid"}, int'(o_sample_valid), 1);
        chk({name, "_clip"}, int'(o_clip), exp_clip);
        tick();
        chk({name, "_pulses"}, vcount - v0, 1);
        chk({name, "_idle"}, int'(o_busy), 0);
    endtask

    initial begin
        int s;
        bit c;
        int v0;

        // Pin the model against hand-computed points.
        mix(8'h80, 8'h80, 10'h300, 10'h200, 4'b0100, 128, 128, 128, s, c);
        chk("model_unity", s, 4096);
        mix(8'hFF, 8'hFF, 10'h3FF, 10'h3FF, 4'b1111, 255, 255, 255, s, c);
        chk("model_sat_hi", s, 32767);
        chk("model_sat_hi_clip", int'(c), 1);
        mix(8'h00, 8'h00, 10'h000, 10'h000, 4'b1111, 255, 255, 255, s, c);
        chk("model_sat_lo", s, -32768);
        mix(8'h90, 8'h00, 10'h000, 10'h000, 4'b0001, 100, 0, 0, s, c);
        chk("model_en", s, 800);

        repeat (3) tick();
        chk("rst_sample", int'(o_sample), 0);
        chk("rst_valid", int'(o_sample_valid), 0);
        chk("rst_busy", int'(o_busy), 0);
        rst = 1'b0;
        tick();

        setup(8'h80, 8'h80, 10'h300, 10'h200, 4'b0100, 8'd128, 8'd128, 8'd128);
        run_mix("unity", 4096, 0);

        setup(8'h80, 8'h80, 10'h200, 10'h200, 4'b1111, 8'd148, 8'd148, 8'd148);
        run_mix("silence", 0, 0);

        setup(8'h90, 8'h00, 10'h000, 10'h000, 4'b0001, 8'd100, 8'd0, 8'd0);
        run_mix("en_on", 800, 0);
        setup(8'h90, 8'h00, 10'h000, 10'h000, 4'b0000, 8'd100, 8'd0, 8'd0);
        run_mix("en_off", 0, 0);

        // Snapshot and overrun: mix A accepted at N, inputs changed at N+1, strobe at N+3
        // ignored, strobe at N+6 accepted with the new inputs.
        setup(8'h80, 8'h80, 10'h300, 10'h200, 4'b0100, 8'd128, 8'd128, 8'd128);
        v0 = vcount;
        strobe();                                   // edge N
        tick();                                     // edge N+1
        setup(8'h90, 8'h00, 10'h000, 10'h000, 4'b0001, 8'd100, 8'd0, 8'd0);
        chk("snap_busy_n1", int'(o_busy), 1);
        tick();                                     // edge N+2
        strobe();                                   // edge N+3 samples the strobe
        chk("ovr_pulse", int'(o_overrun), 1);
        tick();                                     // edge N+4
        chk("ovr_clear", int'(o_overrun), 0);
        chk("ovr_busy", int'(o_busy), 1);
        tick();                                     // edge N+5
        chk("snap_sample", $signed(o_sample), 4096);
        chk("snap_valid", int'(o_sample_valid), 1);
        strobe();                                   // edge N+6 accepts
        chk("n6_busy", int'(o_busy), 0);
        chk("n6_no_ovr", int'(o_overrun), 0);
        repeat (5) tick();
        chk("n6_sample", $signed(o_sample), 800);
        tick();
        chk("snap_pulses", vcount - v0, 2);

        // Saturation both ways; clip is sticky.
        setup(8'hFF, 8'hFF, 10'h3FF, 10'h3FF, 4'b1111, 8'd255, 8'd255, 8'd255);
        run_mix("sat_hi", 32767, 1);
        setup(8'h00, 8'h00, 10'h000, 10'h000, 4'b1111, 8'd255, 8'd255, 8'd255);
        run_mix("sat_lo", -32768, 1);
        setup(8'h80, 8'h80, 10'h200, 10'h200, 4'b1111, 8'd148, 8'd148, 8'd148);
        run_mix("clip_sticky", 0, 1);

        // Reset mid-mix at N+2: outputs clear at once, the aborted mix never publishes.
        setup(8'h80, 8'h80, 10'h300, 10'h200, 4'b0100, 8'd128, 8'd128, 8'd128);
        v0 = vcount;
        strobe();
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("rstmid_busy", int'(o_busy), 0);
        chk("rstmid_clip", int'(o_clip), 0);
        chk("rstmid_sample", int'(o_sample), 0);
        tick();
        rst = 1'b0;
        repeat (8) tick();
        chk("rstmid_no_valid", vcount - v0, 0);
        setup(8'h90, 8'h00, 10'h000, 10'h000, 4'b0001, 8'd100, 8'd0, 8'd0);
        run_mix("after_rst", 800, 0);

        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
